// File: rtl/uart_tx_if.sv
// Transmit request / serial line bundle between the command logic and uart_tx.
// master = requester (command side), slave = uart_tx.
interface uart_tx_if #(
  parameter int WIDTH_WORD = 8
);
  logic                  i_rate;
  logic                  i_tx_start;
  logic [WIDTH_WORD-1:0] i_data_in;
  logic                  o_bit_tx;
  logic                  o_tx_busy;
  logic                  o_tx_done;

  modport master (
    output i_rate, i_tx_start, i_data_in,
    input  o_bit_tx, o_tx_busy, o_tx_done
  );

  modport slave (
    input  i_rate, i_tx_start, i_data_in,
    output o_bit_tx, o_tx_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter clocked by the shared 16x baud tick: start, LSB-first data, stop bits.
// Optional even parity bit compiled in with `define UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for i_tx_start
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, shifting out of shift
// PARITY | even parity of the latched word (UART_TX_PARITY_EN only)
// STOP   | CANT_BIT_STOP stop bits (1), then done pulse
module uart_tx #(
  parameter int WIDTH_WORD    = 8,
  parameter int CANT_BIT_STOP = 2,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic     i_clock,
  input  logic     i_reset,
  uart_tx_if.slave bus
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH_WORD) + 1;
  localparam int SW = $clog2(CANT_BIT_STOP) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_WORD - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(CANT_BIT_STOP - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;
`endif

  state_t                state, state_nxt;
  logic [TW-1:0]         tick, tick_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [SW-1:0]         stop_cnt, stop_cnt_nxt;
  logic [WIDTH_WORD-1:0] shift, shift_nxt;
  logic                  bit_tx, bit_tx_nxt;
  logic                  busy, busy_nxt;
  logic                  done, done_nxt;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity, parity_nxt;
`endif

  assign bit_end = bus.i_rate && (tick == TICK_LAST);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      shift    <= '0;
      bit_tx   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tick     <= tick_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      shift    <= shift_nxt;
      bit_tx   <= bit_tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shift_nxt    = shift;
    bit_tx_nxt   = bit_tx;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt   = parity;
`endif

    // Tick counter only runs inside a frame; it wraps on each bit end.
    if (state != IDLE && bus.i_rate)
      tick_nxt = bit_end ? '0 : tick + 1'b1;

    case (state)
      IDLE: begin
        bit_tx_nxt = 1'b1;
        busy_nxt   = 1'b0;
        if (bus.i_tx_start) begin
          state_nxt    = START;
          shift_nxt    = bus.i_data_in;
          tick_nxt     = '0;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = '0;
          bit_tx_nxt   = 1'b0;
          busy_nxt     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_nxt   = ^bus.i_data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt  = DATA;
          bit_tx_nxt = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_nxt  = PARITY;
            bit_tx_nxt = parity;
`else
            state_nxt  = STOP;
            bit_tx_nxt = 1'b1;
`endif
          end else begin
            bit_tx_nxt = shift_nxt[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt  = STOP;
          bit_tx_nxt = 1'b1;
        end
      end
`endif
      STOP: begin
        bit_tx_nxt = 1'b1;
        if (bit_end) begin
          stop_cnt_nxt = stop_cnt + 1'b1;
          if (stop_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        tick_nxt   = '0;
        bit_tx_nxt = 1'b1;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.o_bit_tx  = bit_tx;
  assign bus.o_tx_busy = busy;
  assign bus.o_tx_done = done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus hand sequences for busy,
// back-to-back and mid-frame reset. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
  localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_if #(.WIDTH_WORD(8)) bus ();

  uart_tx #(
    .WIDTH_WORD(8),
    .CANT_BIT_STOP(2),
    .TICKS_PER_BIT(TPB)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rate_div = 1;
  int rate_ph = 0;

  // frame bit i = i-th bit on the line after accept
  typedef struct {
    logic [7:0]  data;
    int          div;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic line, logic busy, logic done);
    check({tag, ".bit_tx"}, bus.o_bit_tx, line);
    check({tag, ".busy"}, bus.o_tx_busy, busy);
    check({tag, ".done"}, bus.o_tx_done, done);
  endtask

  task automatic drive_rate();
    bus.i_rate = (rate_ph == 0);
    rate_ph = (rate_ph + 1 >= rate_div) ? 0 : rate_ph + 1;
  endtask

  task automatic idle_check(int k, string tag);
    for (int i = 0; i < k; i++) begin
      drive_rate();
      @(negedge clk);
      check_outs(tag, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Accept happens on the first edge; returns at the negedge after the done edge.
  task automatic run_frame(input logic [7:0] data, input int div, input logic [11:0] frame,
                           input bit keep_start, input bit poke);
    int len;
    len = NB * TPB * div;
    bus.i_data_in  = data;
    bus.i_tx_start = 1'b1;
    rate_div = div;
    rate_ph  = 0;
    drive_rate();
    @(negedge clk);
    for (int n = 0; n <= len; n++) begin
      if (n < len) check_outs("frame", frame[n / (TPB * div)], 1'b1, 1'b0);
      else         check_outs("frame_end", 1'b1, 1'b0, 1'b1);
      if (!keep_start) bus.i_tx_start = poke && (n == 49);
      if (poke && n == 49) bus.i_data_in = 8'hFF;
      else if (n == 20)    bus.i_data_in = ~data;
      if (n < len) begin
        drive_rate();
        @(negedge clk);
      end
    end
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 1, 12'hD4A};
    vecs[1] = '{8'h3C, 4, 12'hC78};
    vecs[2] = '{8'h00, 1, 12'hC00};
    vecs[3] = '{8'hFF, 2, 12'hDFE};
    vecs[4] = '{8'h01, 3, 12'hE02};
`else
    vecs[0] = '{8'hA5, 1, 12'h74A};
    vecs[1] = '{8'h3C, 4, 12'h678};
    vecs[2] = '{8'h00, 1, 12'h600};
    vecs[3] = '{8'hFF, 2, 12'h7FE};
    vecs[4] = '{8'h01, 3, 12'h602};
`endif

    bus.i_rate     = 1'b0;
    bus.i_tx_start = 1'b0;
    bus.i_data_in  = 8'h00;

    // reset, then idle
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    rate_div = 1;
    rate_ph  = 0;
    idle_check(100, "idle");

    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].div, vecs[i].frame, 1'b0, 1'b0);
      bus.i_tx_start = 1'b0;
      idle_check(20, "post_frame");
    end

    // start while busy is ignored: only the 00 frame goes out
    run_frame(8'h00, 1, vecs[2].frame, 1'b0, 1'b1);
    bus.i_tx_start = 1'b0;
    idle_check(400, "busy_ignore");

    // back-to-back with start held high: next accept on the edge after done
`ifdef UART_TX_PARITY_EN
    run_frame(8'h55, 1, 12'hCAA, 1'b1, 1'b0);
    run_frame(8'hAA, 1, 12'hD54, 1'b1, 1'b0);
`else
    run_frame(8'h55, 1, 12'h6AA, 1'b1, 1'b0);
    run_frame(8'hAA, 1, 12'h754, 1'b1, 1'b0);
`endif
    bus.i_tx_start = 1'b0;
    idle_check(20, "b2b_tail");

    // reset during DATA bit 3 (line bits 64..79), then a clean frame
    bus.i_data_in  = 8'hA5;
    bus.i_tx_start = 1'b1;
    rate_div = 1;
    rate_ph  = 0;
    drive_rate();
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    for (int n = 0; n < 70; n++) begin
      check_outs("pre_rst", vecs[0].frame[n / TPB], 1'b1, 1'b0);
      drive_rate();
      @(negedge clk);
    end
    check_outs("rst_bit3", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive_rate();
    @(negedge clk);
    check_outs("rst_mid", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_check(50, "after_rst");
    run_frame(vecs[1].data, 1, vecs[1].frame, 1'b0, 1'b0);
    bus.i_tx_start = 1'b0;
    idle_check(5, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Serialises a WIDTH_WORD-bit word onto a single line: start bit (0), data LSB first, optional parity, CANT_BIT_STOP stop bits (1).
- Bit timing comes from the same 16x baud tick that feeds the receiver.
- Sits between the command/ALU interface logic and the board TX pin.

Parameters:
WIDTH_WORD, 8, data bits per frame
CANT_BIT_STOP, 2, number of stop bits (>=1)
TICKS_PER_BIT, 16, i_rate pulses per serial bit

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-low reset
i_rate  input  1  one-i_clock-wide baud tick, 16x bit rate
i_tx_start  input  1  request to send i_data_in; sampled only in IDLE
i_data_in  input  WIDTH_WORD  word to transmit
o_bit_tx  output  1  serial line, registered, idles high
o_tx_busy  output  1  high from the accepting edge until return to IDLE
o_tx_done  output  1  one-i_clock pulse at frame end

Behaviour:
- Reset: when i_reset==0 at a rising edge:
  - o_bit_tx=1, o_tx_busy=0, o_tx_done=0.
  - State IDLE; tick counter, bit counter, stop counter and shift register all 0.
  - Applies immediately mid-frame: the line returns high on that edge and the partial frame is abandoned.
- States (one-hot): IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - o_bit_tx=1.
  - If i_tx_start==1 at an edge: latch i_data_in into the shift register, clear the tick counter, enter START, drive o_bit_tx=0 and o_tx_busy=1 on that same edge.
  - i_rate is not required for acceptance.
- Bit timing:
  - The tick counter (width clog2(TICKS_PER_BIT)) increments only on edges where i_rate==1.
  - A bit ends on the edge where i_rate==1 and tick counter==TICKS_PER_BIT-1; the counter wraps to 0 on that edge.
  - Each bit therefore lasts exactly TICKS_PER_BIT i_rate pulses.
- START: at bit end, go to DATA and drive o_bit_tx=shift[0].
- DATA:
  - At each bit end, shift right and increment the bit counter (width clog2(WIDTH_WORD)+1).
  - After bit WIDTH_WORD-1 ends, go to PARITY if compiled in, else STOP, driving o_bit_tx=1 (or the parity bit).
- STOP:
  - o_bit_tx=1.
  - At each bit end, increment the stop counter.
  - On the end of stop bit CANT_BIT_STOP: go to IDLE, o_tx_busy=0, o_tx_done=1 for exactly that one cycle.
- i_tx_start while o_tx_busy==1 is ignored; i_data_in changes during a frame have no effect.
- Back-to-back: i_tx_start held high continuously starts the next frame on the first edge in IDLE, i.e. the edge after o_tx_done. No idle bit is inserted; the line stays high for at least 1 clock.
- Frame length: (1+WIDTH_WORD+P+CANT_BIT_STOP)*TICKS_PER_BIT i_rate pulses, where P=1 with parity, else 0.
- Illegal state encodings go to IDLE with o_bit_tx=1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP, lasting one bit time.
  - o_bit_tx = XOR of the latched data word (even parity).
- Undefined:
  - PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
1. Reset then idle: i_reset=0 for 2 clocks, then 1, no start -> o_bit_tx=1, o_tx_busy=0, o_tx_done=0 for 100 clocks.
2. Single frame, i_rate=1 every clock, i_data_in=8'hA5 -> line sequence 0,1,0,1,0,0,1,0,1,1,1, each held 16 clocks; o_tx_done pulses once at clock 176 after accept (192 with parity, parity bit=0).
3. Sparse tick: i_rate every 4th clock, data 8'h3C -> every bit is 64 clocks long; the receiver bench decodes 8'h3C with o_rx_done asserted.
4. Start while busy: assert i_tx_start with 8'hFF at clock 50 of a frame carrying 8'h00 -> frame carries 8'h00 only; no second frame follows.
5. Back-to-back: i_tx_start held high, data 8'h55 then 8'hAA -> two contiguous frames, one o_tx_done pulse after each, start bits separated by exactly 176 clocks + 1.
6. Reset mid-frame: i_reset=0 during DATA bit 3 -> o_bit_tx=1 on that edge, busy=0, no o_tx_done; a following start sends a complete, correct frame.
